// File: rtl/johnson_decoder.sv
// Johnson counter phase decoder: samples an N-stage Johnson state, decodes its
// phase, tracks single-step progress and counts revolutions, with sticky fault flags.
module johnson_decoder #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     q_in,
    input  logic             err_clr,
    output logic [W-1:0]     phase_idx,
    output logic [2*N-1:0]   phase_onehot,
    output logic             valid,
    output logic             illegal,
    output logic             step_err,
    output logic             rev_pulse,
    output logic [15:0]      rev_count
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(2 * N - 1);
    localparam logic [W-1:0] ONE_IDX  = {{(W-1){1'b0}}, 1'b1};

    // True when the set bits form one unbroken run starting at bit 0 (includes zero).
    function automatic logic ones_contig(input logic [N-1:0] v);
        return (v & (v + {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}};
    endfunction

    function automatic logic [W-1:0] popcnt(input logic [N-1:0] v);
        logic [W-1:0] c;
        c = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + {{(W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [N-1:0]   q_in_q;
    logic           q_vld_q;
    state_t         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [2*N-1:0] onehot_q, onehot_d;
    logic           valid_q, valid_d;
    logic           illegal_q, illegal_d;
    logic           step_q, step_d;
    logic           pulse_q, pulse_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           dec_legal_s;
    logic [W-1:0]   dec_idx_s;
    logic [W-1:0]   idx_next_s;

    // Input sample register; q_vld_q masks the reset value until a real sample lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_in_q  <= {N{1'b0}};
            q_vld_q <= 1'b0;
        end else begin
            q_in_q  <= q_in;
            q_vld_q <= 1'b1;
        end
    end

    // Pattern decode: low half counts ones, high half counts zeros offset by N.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_idx_s   = {W{1'b0}};
        if (q_in_q[N-1] == 1'b0) begin
            dec_legal_s = ones_contig(q_in_q);
            dec_idx_s   = popcnt(q_in_q);
        end else begin
            dec_legal_s = ones_contig(~q_in_q);
            dec_idx_s   = W'(N) + popcnt(~q_in_q);
        end
    end

    assign idx_next_s = (idx_q == LAST_IDX) ? {W{1'b0}} : idx_q + ONE_IDX;

    // Tracking FSM next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        step_d    = step_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ST_SYNC: begin
                if (!q_vld_q) begin
                    valid_d = 1'b0;
                end else if (dec_legal_s) begin
                    idx_d   = dec_idx_s;
                    valid_d = 1'b1;
                    state_d = ST_TRACK;
                end else begin
                    illegal_d = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = ST_FAULT;
                end
            end
            ST_TRACK: begin
                // Illegal outranks a jump, so step_err is left alone on bad patterns.
                if (!dec_legal_s) begin
                    illegal_d = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = ST_FAULT;
                end else if (dec_idx_s == idx_q) begin
                    idx_d = idx_q;
                end else if (dec_idx_s == idx_next_s) begin
                    idx_d = dec_idx_s;
                    if (idx_q == LAST_IDX) begin
                        pulse_d = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        pulse_d = 1'b0;
                    end
                end else begin
                    step_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
                if (err_clr) begin
                    illegal_d = 1'b0;
                    step_d    = 1'b0;
                    state_d   = ST_SYNC;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_FAULT;
            end
        endcase
        onehot_d = valid_d ? ({{(2*N-1){1'b0}}, 1'b1} << idx_d) : {(2*N){1'b0}};
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            idx_q     <= {W{1'b0}};
            onehot_q  <= {(2*N){1'b0}};
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            step_q    <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            step_q    <= step_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    assign phase_idx    = idx_q;
    assign phase_onehot = onehot_q;
    assign valid        = valid_q;
    assign illegal      = illegal_q;
    assign step_err     = step_q;
    assign rev_pulse    = pulse_q;
    assign rev_count    = cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=8): walk, stall, illegal, jump, wrap, async reset.
module tb_johnson_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  q_in;
    logic        err_clr;
    logic [3:0]  phase_idx;
    logic [15:0] phase_onehot;
    logic        valid, illegal, step_err, rev_pulse;
    logic [15:0] rev_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] jt [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    johnson_decoder #(.N(8), .W(4)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .err_clr(err_clr),
        .phase_idx(phase_idx), .phase_onehot(phase_onehot), .valid(valid),
        .illegal(illegal), .step_err(step_err), .rev_pulse(rev_pulse),
        .rev_count(rev_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, advance to the next falling edge.
    task automatic cyc(input logic [7:0] q, input logic c = 1'b0);
        q_in    = q;
        err_clr = c;
        @(negedge clk);
    endtask

    task automatic chk_phase(input string tag, input int idx);
        chk({tag, "_idx"}, {28'd0, phase_idx}, idx);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_onehot"}, {16'd0, phase_onehot}, 32'd1 << idx);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_idx"}, {28'd0, phase_idx}, 32'd0);
        chk({tag, "_onehot"}, {16'd0, phase_onehot}, 32'd0);
        chk({tag, "_flags"}, {28'd0, valid, illegal, step_err, rev_pulse}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, rev_count}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        q_in    = 8'h00;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");

        reset = 1'b0;
        cyc(jt[0]);
        chk("first_valid_low", {31'd0, valid}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(jt[i]);
            chk_phase("walk", i - 1);
            chk("walk_pulse", {31'd0, rev_pulse}, 32'd0);
        end
        cyc(jt[0]);
        chk_phase("walk15", 15);
        cyc(jt[0]);
        chk_phase("wrap1", 0);
        chk("wrap1_pulse", {31'd0, rev_pulse}, 32'd1);
        chk("wrap1_cnt", {16'd0, rev_count}, 32'd1);
        cyc(jt[1]);
        chk("stall0_pulse", {31'd0, rev_pulse}, 32'd0);
        chk("stall0_cnt", {16'd0, rev_count}, 32'd1);

        for (int i = 2; i <= 8; i++) cyc(jt[i]);
        for (int k = 0; k < 5; k++) begin
            cyc(8'hFF);
            chk_phase("hold8", 8);
            chk("hold8_err", {30'd0, illegal, step_err}, 32'd0);
            chk("hold8_pulse", {31'd0, rev_pulse}, 32'd0);
        end
        for (int i = 9; i < 16; i++) cyc(jt[i]);
        cyc(jt[0]);
        chk_phase("hold_walk15", 15);
        cyc(jt[0]);
        chk("wrap2_pulse", {31'd0, rev_pulse}, 32'd1);
        chk("wrap2_cnt", {16'd0, rev_count}, 32'd2);
        cyc(jt[0]);
        chk("stall_at0_pulse", {31'd0, rev_pulse}, 32'd0);
        chk("stall_at0_cnt", {16'd0, rev_count}, 32'd2);

        cyc(jt[1]); cyc(jt[2]); cyc(jt[3]); cyc(jt[3]);
        chk_phase("at3", 3);
        cyc(8'h05);
        cyc(8'h05);
        chk("ill_illegal", {31'd0, illegal}, 32'd1);
        chk("ill_valid", {31'd0, valid}, 32'd0);
        chk("ill_idx", {28'd0, phase_idx}, 32'd3);
        chk("ill_onehot", {16'd0, phase_onehot}, 32'd0);
        chk("ill_step", {31'd0, step_err}, 32'd0);
        cyc(jt[3]);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);
        cyc(jt[3], 1'b1);
        chk("ill_clr", {30'd0, illegal, valid}, 32'd0);
        cyc(jt[3]);
        chk_phase("resync3", 3);

        cyc(jt[6]);
        chk_phase("pre_jump", 3);
        cyc(jt[6]);
        chk("jump_step", {31'd0, step_err}, 32'd1);
        chk("jump_illegal", {31'd0, illegal}, 32'd0);
        chk("jump_valid", {31'd0, valid}, 32'd0);
        chk("jump_idx", {28'd0, phase_idx}, 32'd3);
        cyc(jt[6], 1'b1);
        chk("jump_clr", {30'd0, step_err, valid}, 32'd0);
        cyc(jt[6]);
        chk_phase("resync6", 6);

        force dut.cnt_q = 16'hFFFF;
        cyc(jt[6]);
        release dut.cnt_q;
        chk("preload_cnt", {16'd0, rev_count}, 32'h0000FFFF);
        for (int i = 7; i < 16; i++) cyc(jt[i]);
        cyc(jt[0]);
        chk("pre_wrap_cnt", {16'd0, rev_count}, 32'h0000FFFF);
        cyc(jt[0]);
        chk_phase("cntwrap", 0);
        chk("cntwrap_cnt", {16'd0, rev_count}, 32'd0);
        chk("cntwrap_pulse", {31'd0, rev_pulse}, 32'd1);

        cyc(jt[1]); cyc(jt[2]); cyc(jt[2]);
        chk_phase("pre_async", 2);
        #2 reset = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
